conv_tile_scheduler: RTL and testbench

//  Sequences the image buffer over a full image: walks 4x4 tile origins in raster order (stride 2),

---
 rtl/conv_pkg.sv | 23 ++
 rtl/tile_addr_gen.sv | 46 ++++
 rtl/conv_tile_scheduler.sv | 140 ++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution tile scheduler.
// Tile geometry, window order and scheduler states.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_CONV,
        S_NEXT,
        S_DONE
    } sched_state_t;

    localparam int TILE_DIM    = 4;
    localparam int TILE_STRIDE = 2;
    localparam int NUM_WIN     = 4;

    localparam logic [1:0] WIN_TL = 2'd0;
    localparam logic [1:0] WIN_TR = 2'd1;
    localparam logic [1:0] WIN_BL = 2'd2;
    localparam logic [1:0] WIN_BR = 2'd3;

endpackage

// File: rtl/tile_addr_gen.sv
// Tile origin generator: raster walk over the image in stride-2 steps.
// Holds the current origin and flags the last tile of the pass.
module tile_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] tile_row,
    output logic [CW-1:0] tile_col,
    output logic          last_tile
);

    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - TILE_DIM);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - TILE_DIM);
    localparam logic [CW-1:0] STEP     = CW'(TILE_STRIDE);

    logic col_last;

    assign col_last  = (tile_col == COL_LAST);
    assign last_tile = col_last && (tile_row == ROW_LAST);

    // Origin register: clear to (0,0), or step right / wrap to next row.
    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            tile_row <= '0;
            tile_col <= '0;
        end else if (advance) begin
            if (last_tile) begin
                tile_row <= '0;
                tile_col <= '0;
            end else if (col_last) begin
                tile_row <= tile_row + STEP;
                tile_col <= '0;
            end else begin
                tile_col <= tile_col + STEP;
            end
        end
    end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Convolution tile scheduler: fetches each 4x4 tile, loads the buffer,
// counts the four window results and tags them with output coordinates.
module conv_tile_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    localparam int CW = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          abort,
    output logic          fetch_req,
    output logic [CW-1:0] fetch_row,
    output logic [CW-1:0] fetch_col,
    input  logic          fetch_ack,
    output logic          load_enable,
    input  logic          calc_done,
    output logic          res_valid,
    output logic [CW-1:0] res_row,
    output logic [CW-1:0] res_col,
    output logic          busy,
    output logic          done,
    output logic          err
);

    sched_state_t  state;
    sched_state_t  state_next;
    logic [1:0]    win;
    logic          tile_clear;
    logic          tile_advance;
    logic          last_tile;
    logic          accept;
    logic [CW-1:0] tile_row;
    logic [CW-1:0] tile_col;

    tile_addr_gen #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .CW   (CW)
    ) u_addr (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (tile_clear),
        .advance  (tile_advance),
        .tile_row (tile_row),
        .tile_col (tile_col),
        .last_tile(last_tile)
    );

    // A window result counts only in CONV and only if not cancelled.
    assign accept = (state == S_CONV) && calc_done && !abort;

    // Next-state and tile-walk control; abort overrides everything.
    always_comb begin
        state_next   = state;
        tile_clear   = 1'b0;
        tile_advance = 1'b0;
        if (abort) begin
            state_next = S_IDLE;
            tile_clear = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_FETCH;
                        tile_clear = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (fetch_ack) begin
                        state_next = S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_next = S_CONV;
                end
                S_CONV: begin
                    if (calc_done && win == WIN_BR) begin
                        state_next = S_NEXT;
                    end
                end
                S_NEXT: begin
                    tile_advance = 1'b1;
                    state_next   = last_tile ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // State-decoded strobes and the fetch origin.
    always_comb begin
        fetch_req   = (state == S_FETCH);
        load_enable = (state == S_LOAD);
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        fetch_row   = tile_row;
        fetch_col   = tile_col;
    end

    // State, window counter, result tagging and sticky error flag.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            win       <= WIN_TL;
            res_valid <= 1'b0;
            res_row   <= '0;
            res_col   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            res_valid <= accept;
            if (abort || state == S_LOAD) begin
                win <= WIN_TL;
            end else if (accept) begin
                win <= win + 2'd1;
            end
            if (abort) begin
                res_row <= '0;
                res_col <= '0;
            end else if (accept) begin
                res_row <= tile_row + CW'(win[1]);
                res_col <= tile_col + CW'(win[0]);
            end
            if (state == S_IDLE && start && !abort) begin
                err <= 1'b0;
            end else if (calc_done && state != S_CONV) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Scoreboard bench for conv_tile_scheduler.
// Two instances: 6x6 image and 8x6 image, selected by sel.
module tb_conv_tile_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;
    logic start;
    logic abort;
    logic fetch_ack;
    logic calc_done;
    logic sel;

    int n_cmp = 0;
    int n_bad = 0;
    int res_cnt = 0;
    logic [7:0] exp_q[$];

    logic       a_fetch_req, a_load_enable, a_res_valid;
    logic       a_busy, a_done, a_err;
    logic [2:0] a_fetch_row, a_fetch_col, a_res_row, a_res_col;
    logic       b_fetch_req, b_load_enable, b_res_valid;
    logic       b_busy, b_done, b_err;
    logic [2:0] b_fetch_row, b_fetch_col, b_res_row, b_res_col;

    conv_tile_scheduler #(.IMG_W(6), .IMG_H(6)) u_a (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start & ~sel),
        .abort      (abort & ~sel),
        .fetch_req  (a_fetch_req),
        .fetch_row  (a_fetch_row),
        .fetch_col  (a_fetch_col),
        .fetch_ack  (fetch_ack & ~sel),
        .load_enable(a_load_enable),
        .calc_done  (calc_done & ~sel),
        .res_valid  (a_res_valid),
        .res_row    (a_res_row),
        .res_col    (a_res_col),
        .busy       (a_busy),
        .done       (a_done),
        .err        (a_err)
    );

    conv_tile_scheduler #(.IMG_W(8), .IMG_H(6)) u_b (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start & sel),
        .abort      (abort & sel),
        .fetch_req  (b_fetch_req),
        .fetch_row  (b_fetch_row),
        .fetch_col  (b_fetch_col),
        .fetch_ack  (fetch_ack & sel),
        .load_enable(b_load_enable),
        .calc_done  (calc_done & sel),
        .res_valid  (b_res_valid),
        .res_row    (b_res_row),
        .res_col    (b_res_col),
        .busy       (b_busy),
        .done       (b_done),
        .err        (b_err)
    );

    logic       m_fetch_req, m_load_enable, m_res_valid;
    logic       m_busy, m_done, m_err;
    logic [2:0] m_fetch_row, m_fetch_col, m_res_row, m_res_col;

    assign m_fetch_req   = sel ? b_fetch_req   : a_fetch_req;
    assign m_load_enable = sel ? b_load_enable : a_load_enable;
    assign m_res_valid   = sel ? b_res_valid   : a_res_valid;
    assign m_busy        = sel ? b_busy        : a_busy;
    assign m_done        = sel ? b_done        : a_done;
    assign m_err         = sel ? b_err         : a_err;
    assign m_fetch_row   = sel ? b_fetch_row   : a_fetch_row;
    assign m_fetch_col   = sel ? b_fetch_col   : a_fetch_col;
    assign m_res_row     = sel ? b_res_row     : a_res_row;
    assign m_res_col     = sel ? b_res_col     : a_res_col;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Result monitor: every res_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (m_res_valid) begin
            res_cnt++;
            if (exp_q.size() == 0) begin
                chk("res_extra", 32'd1, 32'd0);
            end else begin
                chk("res_coord",
                    {24'd0, 1'b0, m_res_row, 1'b0, m_res_col},
                    {24'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [31:0] outs();
        return {16'd0, m_fetch_req, m_fetch_row, m_fetch_col,
                m_load_enable, m_res_valid, m_res_row, m_res_col,
                m_busy, m_done, m_err};
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (m_fetch_req) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_pass(input int w, input int h, input int gap,
                            input int stall);
        bit ok;
        int base;
        int tiles;
        base  = res_cnt;
        tiles = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r <= h - 4; r += 2) begin
            for (int c = 0; c <= w - 4; c += 2) begin
                wait_req(ok);
                if (!ok) return;
                tiles++;
                chk("fetch_row", 32'(m_fetch_row), 32'(r));
                chk("fetch_col", 32'(m_fetch_col), 32'(c));
                for (int s = 0; s < stall; s++) begin
                    tick();
                    chk("stall_req", 32'(m_fetch_req), 32'd1);
                    chk("stall_row", 32'(m_fetch_row), 32'(r));
                    chk("stall_col", 32'(m_fetch_col), 32'(c));
                    chk("stall_load", 32'(m_load_enable), 32'd0);
                end
                fetch_ack = 1'b1;
                tick();
                fetch_ack = 1'b0;
                chk("load_en", 32'(m_load_enable), 32'd1);
                chk("load_req", 32'(m_fetch_req), 32'd0);
                tick();
                chk("load_once", 32'(m_load_enable), 32'd0);
                for (int wi = 0; wi < 4; wi++) begin
                    repeat (gap - 1) tick();
                    exp_q.push_back(8'((r + wi / 2) * 16 + c + wi % 2));
                    calc_done = 1'b1;
                    tick();
                    calc_done = 1'b0;
                end
            end
        end
        chk("done_lat1", 32'(m_done), 32'd0);
        tick();
        chk("done_lat2", 32'(m_done), 32'd1);
        tick();
        chk("done_pulse", 32'(m_done), 32'd0);
        chk("busy_after", 32'(m_busy), 32'd0);
        chk("res_count", 32'(res_cnt - base), 32'(4 * tiles));
        chk("res_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic enter_conv();
        bit ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_req(ok);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        tick();
    endtask

    initial begin
        n_rst     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        fetch_ack = 1'b0;
        calc_done = 1'b0;
        sel       = 1'b0;
        repeat (2) tick();
        chk("por_outs", outs(), 32'd0);
        n_rst = 1'b1;
        repeat (3) tick();
        chk("idle_busy", 32'(m_busy), 32'd0);

        // reset while in CONV
        enter_conv();
        chk("conv_busy", 32'(m_busy), 32'd1);
        n_rst = 1'b0;
        tick();
        chk("rst_outs", outs(), 32'd0);
        n_rst = 1'b1;
        repeat (3) tick();
        chk("rst_idle", 32'(m_busy), 32'd0);
        chk("rst_noreq", 32'(m_fetch_req), 32'd0);

        // full pass, then pass with ack stalls
        run_pass(6, 6, 3, 0);
        run_pass(6, 6, 3, 10);

        // abort with a coincident calc_done after two windows
        enter_conv();
        for (int wi = 0; wi < 2; wi++) begin
            repeat (2) tick();
            exp_q.push_back(8'((wi / 2) * 16 + wi % 2));
            calc_done = 1'b1;
            tick();
            calc_done = 1'b0;
        end
        repeat (2) tick();
        calc_done = 1'b1;
        abort     = 1'b1;
        tick();
        calc_done = 1'b0;
        abort     = 1'b0;
        chk("abort_busy", 32'(m_busy), 32'd0);
        chk("abort_res", 32'(m_res_valid), 32'd0);
        chk("abort_coord", {26'd0, m_res_row, m_res_col}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_done", 32'(m_done), 32'd0);
        end
        run_pass(6, 6, 3, 0);

        // stray calc_done in IDLE, start clears err, start while busy
        tick();
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        chk("err_set", 32'(m_err), 32'd1);
        chk("stray_res", 32'(m_res_valid), 32'd0);
        tick();
        chk("err_sticky", 32'(m_err), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_clr", 32'(m_err), 32'd0);
        chk("start_req", 32'(m_fetch_req), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_req", 32'(m_fetch_req), 32'd1);
        chk("busy_start_org", {26'd0, m_fetch_row, m_fetch_col}, 32'd0);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("conv_start_req", 32'(m_fetch_req), 32'd0);
        chk("conv_start_load", 32'(m_load_enable), 32'd0);
        chk("conv_start_busy", 32'(m_busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("clean_idle", 32'(m_busy), 32'd0);

        // 8x6 image on the second instance
        sel   = 1'b1;
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        chk("b_rst_outs", outs(), 32'd0);
        run_pass(8, 6, 3, 0);
        chk("b_err", 32'(m_err), 32'd0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
